start_fetch_unit: RTL and testbench

- Parametrised successor to the per-CPU start/fetch stage.
- Holds a base address per CPU context and fetches that context's saved IP from its register window (base + REG_IP_OFS).
- Fetches a multi-word command at the IP, then writes the advanced or redirected IP back once execution completes.
- Sits between the CPU state sequencer and the dispatcher bus; it owns bus requests only while it holds grant (disp_online).

---
 rtl/start_fetch_unit_if.sv | 38 +++
 rtl/start_fetch_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_start_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/start_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// start_fetch_unit_if
// Dispatcher bus between the start/fetch unit (master) and the dispatcher
// (slave).
//   addr        : request address, valid with read_q / write_q
//   data_out    : write data, valid with write_q
//   read_q      : one-cycle read request pulse
//   write_q     : one-cycle write request pulse
//   halt_q      : a transaction is outstanding
//   data_in     : read data, valid with read_dn
//   read_dn     : read completion
//   write_dn    : write completion
//   disp_online : bus grant; the master issues only while it is high
// ----------------------------------------------------------------------------
interface start_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;
    logic              read_q;
    logic              write_q;
    logic              halt_q;
    logic [DATA_W-1:0] data_in;
    logic              read_dn;
    logic              write_dn;
    logic              disp_online;

    modport master (
        output addr, data_out, read_q, write_q, halt_q,
        input  data_in, read_dn, write_dn, disp_online
    );

    modport slave (
        input  addr, data_out, read_q, write_q, halt_q,
        output data_in, read_dn, write_dn, disp_online
    );
endinterface

// File: rtl/start_fetch_unit.sv
// ----------------------------------------------------------------------------
// start_fetch_unit
// Per-context start/fetch stage. Holds one base address per CPU context,
// reads the saved IP from base + REG_IP_OFS, fetches a CMD_WORDS-word command
// at that IP, waits for execution to finish and writes the advanced (or
// redirected) IP back to the register window.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   start, ctx_sel      : begin a fetch for context ctx_sel (IDLE only)
//   base_wr, base_wdata : load base[ctx_sel]
//   exec_done, jmp_valid, jmp_addr : end of execution, optional redirect
//   bus                 : dispatcher bus (master side)
//   cmd, cmd_valid      : fetched command (word 0 in LSBs) and its valid flag
//   cmd_ptr             : IP of the current command
//   base_addr           : base of the active context
//   busy, done, err     : FSM not idle, write-back done pulse, timeout pulse
//
// Optional feature: define STARTMGR_TIMEOUT_EN to abort a transaction that
// receives no completion within TIMEOUT_CYC cycles of its request pulse.
// Without it the unit waits indefinitely and err is constant 0.
// ----------------------------------------------------------------------------
module start_fetch_unit #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              NCTX        = 4,
    parameter int              CTX_W       = 2,
    parameter int              CMD_WORDS   = 2,
    parameter logic [ADDR_W-1:0] REG_IP_OFS = ADDR_W'(1'b0),
    parameter logic [ADDR_W-1:0] BASE_RST   = ADDR_W'(1'b1),
    parameter int              TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CTX_W-1:0]            ctx_sel,
    input  logic                        base_wr,
    input  logic [ADDR_W-1:0]           base_wdata,
    input  logic                        exec_done,
    input  logic                        jmp_valid,
    input  logic [ADDR_W-1:0]           jmp_addr,
    start_fetch_unit_if.master          bus,
    output logic [CMD_WORDS*DATA_W-1:0] cmd,
    output logic                        cmd_valid,
    output logic [ADDR_W-1:0]           cmd_ptr,
    output logic [ADDR_W-1:0]           base_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_IP     = 3'd1,
        ST_RD_CMD    = 3'd2,
        ST_WAIT_EXEC = 3'd3,
        ST_WR_IP     = 3'd4
    } state_t;

    state_t                      state_r;
    logic [ADDR_W-1:0]           base_r [NCTX];
    logic [CTX_W-1:0]            active_r;
    logic [ADDR_W-1:0]           cmd_ptr_r;
    logic [ADDR_W-1:0]           next_ip_r;
    logic [ADDR_W-1:0]           addr_r;
    logic [DATA_W-1:0]           data_out_r;
    logic [CMD_WORDS*DATA_W-1:0] cmd_r;
    logic [2:0]                  idx_r;      // word currently requested / awaited
    logic                        cmd_valid_r;
    logic                        read_q_r;
    logic                        write_q_r;
    logic                        halt_q_r;   // doubles as the "outstanding" flag
    logic                        done_r;

    logic [ADDR_W-1:0]           ip_addr_s;
    logic                        rd_cpl_s;
    logic                        wr_cpl_s;
    logic                        bus_free_s;
    logic                        last_word_s;
    logic                        base_we_s;
    logic                        tmo_s;

`ifdef STARTMGR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;
`endif

    // Completion qualification, issue eligibility and base write acceptance.
    always_comb begin
        ip_addr_s   = base_r[active_r] + REG_IP_OFS;
        // Completions count only while halt_q is up, so one that lands in the
        // request-pulse cycle or with nothing outstanding is dropped.
        rd_cpl_s    = halt_q_r & bus.read_dn &
                      ((state_r == ST_RD_IP) | (state_r == ST_RD_CMD));
        wr_cpl_s    = halt_q_r & bus.write_dn & (state_r == ST_WR_IP);
        bus_free_s  = ~read_q_r & ~write_q_r & ~halt_q_r;
        last_word_s = (idx_r == 3'(CMD_WORDS - 1));
        base_we_s   = base_wr & ((state_r == ST_IDLE) | (ctx_sel != active_r));
`ifdef STARTMGR_TIMEOUT_EN
        tmo_s = halt_q_r & ~(rd_cpl_s | wr_cpl_s) &
                (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 2));
`else
        tmo_s = 1'b0;
`endif
    end

`ifdef STARTMGR_TIMEOUT_EN
    // Cycles spent with halt_q high; the request pulse precedes the first one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= '0;
        end else if (halt_q_r) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end
`endif

    // Per-context base registers; the active context is frozen while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCTX; i++) begin
                base_r[i] <= BASE_RST;
            end
        end else if (base_we_s) begin
            base_r[ctx_sel] <= base_wdata;
        end
    end

    // Main sequencer: bus requests, command capture and IP write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            active_r    <= '0;
            cmd_ptr_r   <= '0;
            next_ip_r   <= '0;
            addr_r      <= '0;
            data_out_r  <= '0;
            cmd_r       <= '0;
            idx_r       <= 3'd0;
            cmd_valid_r <= 1'b0;
            read_q_r    <= 1'b0;
            write_q_r   <= 1'b0;
            halt_q_r    <= 1'b0;
            done_r      <= 1'b0;
`ifdef STARTMGR_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
        end else begin
            read_q_r  <= 1'b0;
            write_q_r <= 1'b0;
            done_r    <= 1'b0;
`ifdef STARTMGR_TIMEOUT_EN
            err_r     <= tmo_s;
`endif
            if (read_q_r | write_q_r) begin
                halt_q_r <= 1'b1;
            end else if (rd_cpl_s | wr_cpl_s | tmo_s) begin
                halt_q_r <= 1'b0;
            end

            if (tmo_s) begin
                state_r     <= ST_IDLE;
                cmd_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            active_r    <= ctx_sel;
                            cmd_valid_r <= 1'b0;
                            idx_r       <= 3'd0;
                            state_r     <= ST_RD_IP;
                        end
                    end
                    ST_RD_IP: begin
                        if (rd_cpl_s) begin
                            cmd_ptr_r <= bus.data_in[ADDR_W-1:0];
                            idx_r     <= 3'd0;
                            state_r   <= ST_RD_CMD;
                            // Word 0 goes out on the completion edge itself.
                            if (bus.disp_online) begin
                                read_q_r <= 1'b1;
                                addr_r   <= bus.data_in[ADDR_W-1:0];
                            end
                        end else if (bus_free_s && bus.disp_online) begin
                            read_q_r <= 1'b1;
                            addr_r   <= ip_addr_s;
                        end
                    end
                    ST_RD_CMD: begin
                        if (rd_cpl_s) begin
                            cmd_r[int'(idx_r)*DATA_W +: DATA_W] <= bus.data_in;
                            if (last_word_s) begin
                                cmd_valid_r <= 1'b1;
                                state_r     <= ST_WAIT_EXEC;
                            end else begin
                                idx_r <= idx_r + 3'd1;
                                if (bus.disp_online) begin
                                    read_q_r <= 1'b1;
                                    addr_r   <= cmd_ptr_r + ADDR_W'(idx_r) + ADDR_W'(1'b1);
                                end
                            end
                        end else if (bus_free_s && bus.disp_online) begin
                            read_q_r <= 1'b1;
                            addr_r   <= cmd_ptr_r + ADDR_W'(idx_r);
                        end
                    end
                    ST_WAIT_EXEC: begin
                        if (exec_done) begin
                            next_ip_r   <= jmp_valid ? jmp_addr
                                                     : cmd_ptr_r + ADDR_W'(CMD_WORDS);
                            cmd_valid_r <= 1'b0;
                            state_r     <= ST_WR_IP;
                        end
                    end
                    ST_WR_IP: begin
                        if (wr_cpl_s) begin
                            cmd_ptr_r <= next_ip_r;
                            done_r    <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else if (bus_free_s && bus.disp_online) begin
                            write_q_r  <= 1'b1;
                            addr_r     <= ip_addr_s;
                            data_out_r <= DATA_W'(next_ip_r);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.addr     = addr_r;
    assign bus.data_out = data_out_r;
    assign bus.read_q   = read_q_r;
    assign bus.write_q  = write_q_r;
    assign bus.halt_q   = halt_q_r;
    assign cmd          = cmd_r;
    assign cmd_valid    = cmd_valid_r;
    assign cmd_ptr      = cmd_ptr_r;
    assign base_addr    = base_r[active_r];
    assign busy         = (state_r != ST_IDLE);
    assign done         = done_r;
`ifdef STARTMGR_TIMEOUT_EN
    assign err          = err_r;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_start_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_start_fetch_unit
// Scoreboard bench: every expected bus request is queued when a fetch or
// write-back is started and compared when the DUT pulses read_q / write_q.
// A zero-wait memory model answers reads from a sparse array.
// ----------------------------------------------------------------------------
module tb_start_fetch_unit;

`ifdef STARTMGR_TIMEOUT_EN
    localparam int TB_TMO = 8;
`else
    localparam int TB_TMO = 64;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  ctx_sel;
    logic        base_wr;
    logic [31:0] base_wdata;
    logic        exec_done;
    logic        jmp_valid;
    logic [31:0] jmp_addr;
    logic [63:0] cmd;
    logic        cmd_valid;
    logic [31:0] cmd_ptr;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;

    logic        grant;
    logic        mem_mute;
    logic        inj_rd_dn;
    logic        mem_rd_dn;
    logic        mem_wr_dn;
    logic [31:0] mem_data;

    logic [31:0] mem [logic [31:0]];
    req_t        exp_q [$];
    logic [63:0] exp_cmd;
    logic [31:0] exp_ptr;
    int          checks_cnt;
    int          errors_cnt;
    int          n;
    int          viol;

    start_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) sbus ();

    start_fetch_unit #(.TIMEOUT_CYC(TB_TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ctx_sel    (ctx_sel),
        .base_wr    (base_wr),
        .base_wdata (base_wdata),
        .exec_done  (exec_done),
        .jmp_valid  (jmp_valid),
        .jmp_addr   (jmp_addr),
        .bus        (sbus),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ptr    (cmd_ptr),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    assign sbus.disp_online = grant;
    assign sbus.read_dn     = mem_rd_dn | inj_rd_dn;
    assign sbus.write_dn    = mem_wr_dn;
    assign sbus.data_in     = mem_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Zero-wait memory: completion in the cycle after the request pulse.
    always @(posedge clk) begin
        mem_rd_dn <= 1'b0;
        mem_wr_dn <= 1'b0;
        if (sbus.read_q && !mem_mute) begin
            mem_rd_dn <= 1'b1;
            mem_data  <= rd_mem(sbus.addr);
        end
        if (sbus.write_q && !mem_mute) begin
            mem_wr_dn <= 1'b1;
        end
    end

    // Scoreboard monitor: every request pulse must match the queue head.
    always @(negedge clk) begin
        if (rst && (sbus.read_q || sbus.write_q)) begin
            if (exp_q.size() == 0) begin
                check_val("req_unexpected", 64'(sbus.addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                check_val("req_kind", 64'(sbus.write_q), 64'(e.wr));
                check_val("req_addr", 64'(sbus.addr), 64'(e.a));
                if (e.wr) check_val("req_data", 64'(sbus.data_out), 64'(e.d));
            end
        end
    end

    task automatic push_req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        req_t e;
        e.wr = wr; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // Set up memory and expectations, then pulse start for one cycle.
    task automatic begin_fetch(input logic [1:0] ctx, input logic [31:0] ip_loc,
                               input logic [31:0] ip, input logic [31:0] w0,
                               input logic [31:0] w1);
        logic [31:0] ip1;
        ip1 = ip + 32'd1;
        mem[ip_loc] = ip;
        mem[ip]     = w0;
        mem[ip1]    = w1;
        push_req(1'b0, ip_loc, 32'h0);
        push_req(1'b0, ip, 32'h0);
        push_req(1'b0, ip1, 32'h0);
        exp_cmd = {w1, w0};
        exp_ptr = ip;
        @(negedge clk);
        ctx_sel = ctx;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Wait (bounded) for cmd_valid; n ends as cycles since start was sampled.
    task automatic wait_cmd();
        n = 1;
        while (!cmd_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("cmd_valid", 64'(cmd_valid), 64'd1);
        check_val("cmd", cmd, exp_cmd);
        check_val("cmd_ptr", 64'(cmd_ptr), 64'(exp_ptr));
    endtask

    task automatic finish_cmd(input logic jv, input logic [31:0] ja,
                              input logic [31:0] ip_loc, input logic [31:0] nxt);
        push_req(1'b1, ip_loc, nxt);
        @(negedge clk);
        exec_done = 1'b1;
        jmp_valid = jv;
        jmp_addr  = ja;
        @(negedge clk);
        exec_done = 1'b0;
        jmp_valid = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("done", 64'(done), 64'd1);
        check_val("wb_cmd_ptr", 64'(cmd_ptr), 64'(nxt));
        check_val("wb_busy", 64'(busy), 64'd0);
        check_val("wb_cmd_valid", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        check_val("done_pulse", 64'(done), 64'd0);
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks_cnt = 0;  errors_cnt = 0;
        rst = 1'b0;      start = 1'b0;     ctx_sel = 2'd0;
        base_wr = 1'b0;  base_wdata = 32'h0;
        exec_done = 1'b0; jmp_valid = 1'b0; jmp_addr = 32'h0;
        grant = 1'b1;    mem_mute = 1'b0;  inj_rd_dn = 1'b0;
        mem_rd_dn = 1'b0; mem_wr_dn = 1'b0; mem_data = 32'h0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_read_q", 64'(sbus.read_q), 64'd0);
        check_val("rst_halt_q", 64'(sbus.halt_q), 64'd0);
        check_val("rst_addr", 64'(sbus.addr), 64'd0);
        check_val("rst_data_out", 64'(sbus.data_out), 64'd0);
        check_val("rst_cmd", cmd, 64'd0);
        check_val("rst_cmd_ptr", 64'(cmd_ptr), 64'd0);
        check_val("rst_base", 64'(base_addr), 64'd1);
        check_val("rst_flags", 64'({cmd_valid, done, err, sbus.write_q}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic fetch from ctx 0 and minimum latency 2 + 2*(1+2) = 8.
        begin_fetch(2'd0, 32'h1, 32'h100, 32'hA, 32'hB);
        wait_cmd();
        check_val("latency", 64'(n), 64'd8);
        finish_cmd(1'b0, 32'h0, 32'h1, 32'h102);

        // Redirected IP.
        begin_fetch(2'd0, 32'h1, 32'h102, 32'hC, 32'hD);
        wait_cmd();
        finish_cmd(1'b1, 32'h40, 32'h1, 32'h40);

        // Address wrap of word fetch and of the advanced IP.
        begin_fetch(2'd0, 32'h1, 32'hFFFF_FFFF, 32'h11, 32'h22);
        wait_cmd();
        finish_cmd(1'b0, 32'h0, 32'h1, 32'h1);

        // Grant dropped during RD_CMD; base writes while busy on ctx 0.
        begin_fetch(2'd0, 32'h1, 32'h200, 32'h21, 32'h22);
        n = 0;
        while (!(sbus.read_q && sbus.addr == 32'h200) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("word0_req_seen", 64'(sbus.read_q), 64'd1);
        grant      = 1'b0;
        base_wr    = 1'b1;
        ctx_sel    = 2'd2;
        base_wdata = 32'h55;
        @(negedge clk);
        ctx_sel    = 2'd0;
        base_wdata = 32'h77;
        @(negedge clk);
        base_wr    = 1'b0;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sbus.read_q || sbus.halt_q) viol++;
        end
        check_val("stall_no_req", 64'(viol), 64'd0);
        check_val("stall_busy", 64'(busy), 64'd1);
        check_val("base_active_kept", 64'(base_addr), 64'd1);
        grant = 1'b1;
        wait_cmd();
        finish_cmd(1'b0, 32'h0, 32'h1, 32'h202);

        // ctx 2 now uses the base written while ctx 0 was busy.
        begin_fetch(2'd2, 32'h55, 32'h300, 32'h31, 32'h32);
        wait_cmd();
        check_val("base_ctx2", 64'(base_addr), 64'h55);
        finish_cmd(1'b0, 32'h0, 32'h55, 32'h302);

`ifdef STARTMGR_TIMEOUT_EN
        // No completion: err 8 cycles after the request pulse.
        mem_mute = 1'b1;
        mem[32'h55] = 32'h400;
        push_req(1'b0, 32'h55, 32'h0);
        @(negedge clk);
        ctx_sel = 2'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n = 0;
        while (!sbus.read_q && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("tmo_delay", 64'(n), 64'd8);
        check_val("tmo_busy", 64'(busy), 64'd0);
        check_val("tmo_halt", 64'(sbus.halt_q), 64'd0);
        check_val("tmo_cmd_ptr", 64'(cmd_ptr), 64'h302);
        @(negedge clk);
        check_val("tmo_err_pulse", 64'(err), 64'd0);
        mem_mute = 1'b0;
`endif

        // Asynchronous reset during RD_CMD, then a stray completion.
        begin_fetch(2'd0, 32'h1, 32'h500, 32'h1, 32'h2);
        n = 0;
        while (!(sbus.read_q && sbus.addr == 32'h500) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("rc_word0_seen", 64'(sbus.read_q), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_bus", 64'({sbus.read_q, sbus.halt_q}), 64'd0);
        check_val("mid_rst_addr", 64'(sbus.addr), 64'd0);
        check_val("mid_rst_cmd_ptr", 64'(cmd_ptr), 64'd0);
        check_val("mid_rst_cmd", cmd, 64'd0);
        check_val("mid_rst_base", 64'(base_addr), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        inj_rd_dn = 1'b1;
        @(negedge clk);
        inj_rd_dn = 1'b0;
        @(negedge clk);
        check_val("late_dn_busy", 64'(busy), 64'd0);
        check_val("late_dn_halt", 64'(sbus.halt_q), 64'd0);
        check_val("late_dn_cmd_ptr", 64'(cmd_ptr), 64'd0);
        check_val("late_dn_cmd", cmd, 64'd0);
        check_val("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
